// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: CPU MEM stage vs host port, CPU priority with starvation guard.
// Optional perf counters (stall_cnt, force_cnt) enabled by MEM_ARB_PERF_CNT_EN.
module data_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              pc_reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       force_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    CPU_PRI = 1'b0,
    EXT_PRI = 1'b1
  } arb_state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  arb_state_t state;
  logic [3:0] wait_cnt;
  logic [3:0] wait_inc;
  logic       cpu_gnt;
  logic       ext_lose;
  logic       force_ev;

  always_comb begin
    ext_gnt   = ext_req & (~cpu_req | (state == EXT_PRI));
    cpu_gnt   = cpu_req & ~ext_gnt;
    cpu_stall = cpu_req & ext_gnt;
    cpu_rdata = mem_rdata;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    unique case (1'b1)
      ext_gnt: begin
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_read  = ~ext_we;
        mem_write = ext_we;
      end
      cpu_gnt: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_read  = ~cpu_we;
        mem_write = cpu_we;
      end
      default: ;
    endcase
  end

  assign wait_inc = wait_cnt + 4'd1;
  assign ext_lose = ext_req & ~ext_gnt;
  assign force_ev = (state == CPU_PRI) & ext_lose
                  & (wait_inc == MAX_W);

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state      <= CPU_PRI;
      wait_cnt   <= 4'd0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      unique case (state)
        CPU_PRI: begin
          if (force_ev) begin
            state    <= EXT_PRI;
            wait_cnt <= 4'd0;
          end else if (ext_lose) begin
            wait_cnt <= wait_inc;
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        EXT_PRI: begin
          wait_cnt <= 4'd0;
          if (ext_gnt | ~ext_req)
            state <= CPU_PRI;
        end
        default: state <= CPU_PRI;
      endcase
      ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt & ~ext_we)
        ext_rdata <= mem_rdata;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      stall_cnt <= 16'd0;
      force_cnt <= 16'd0;
    end else begin
      if (cpu_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (force_ev && force_cnt != 16'hFFFF)
        force_cnt <= force_cnt + 16'd1;
    end
  end
`endif

endmodule
